spi_rx_sampled: RTL and testbench
=================================

Name: spi_rx_sampled

Overview:
SPI slave receiver, mode 0, MSB first; complements the sck-clocked slave transmitter.
- Runs entirely in the system clock domain and oversamples spi_sck, spi_csn and spi_sdi through synchronizers, so no clock-domain crossing handshake is needed.
- Assembles 8-bit bytes and queues them in a small FIFO.
- Presents bytes on a valid/ready stream for the wishbone-side controller logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages per synchronized SPI input (minimum 2).
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; must be at least 4x spi_sck frequency, with each sck phase at least 2 clk periods.
rst_n  input  1  asynchronous, active-low reset.
spi_sck  input  1  SPI clock from controller, asynchronous to clk.
spi_csn  input  1  SPI chip select, active low, asynchronous.
spi_sdi  input  1  SPI data from controller, asynchronous; sampled on the sck rising edge.
rx_data  output  8  head-of-FIFO byte; valid only while rx_valid is high.
rx_valid  output  1  FIFO non-empty.
rx_ready  input  1  consumer accepts; a pop occurs when rx_valid && rx_ready.
rx_overrun  output  1  sticky; a completed byte was dropped because the FIFO was full.
rx_overrun_clr  input  1  single-cycle pulse that clears rx_overrun.
spi_active  output  1  synchronized ~spi_csn.

Behaviour:
- Reset (asynchronous assert, released on clk):
  - Synchronizer chains: sck=0, csn=1, sdi=0.
  - Internal state: sck_prev=0, bit_cnt=0, shift_reg=0, FIFO empty.
  - Outputs: rx_valid=0, rx_data=0, rx_overrun=0, spi_active=0.
- Edge detect:
  - edge = sck_s && !sck_prev && !csn_s, where _s denotes the final synchronizer stage.
  - sck_prev is registered from sck_s every cycle.
- On edge with bit_cnt < 7:
  - shift_reg <= {shift_reg[6:0], sdi_s}.
  - bit_cnt increments.
- On edge with bit_cnt == 7:
  - Byte {shift_reg[6:0], sdi_s} is pushed to the FIFO.
  - bit_cnt wraps to 0; shift_reg cleared.
- csn_s high (deselected):
  - bit_cnt and shift_reg are held at 0; any partial byte is silently discarded.
  - An sck rise in the same cycle as csn_s high is ignored.
- Latency:
  - Pad to _s takes SYNC_STAGES cycles.
  - The push happens at the end of edge cycle E; rx_valid and rx_data are visible in cycle E+1 if the FIFO was empty.
  - There is no combinational bypass from SPI input to rx_data.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits; full/empty are derived from pointer MSB comparison.
  - rx_data reads the head entry combinationally from the storage array.
  - Pop with rx_valid=0 has no effect.
- Full plus simultaneous pop and push: push is accepted; no overrun.
- Full, push, no pop: byte dropped, rx_overrun <= 1, FIFO contents unchanged.
- rx_overrun_clr in the same cycle as a new drop: set wins, rx_overrun stays 1.
- rx_overrun_clr alone: rx_overrun <= 0 next cycle.
- Reset mid-byte or mid-frame: all state returns to reset values; the receiver resynchronizes only from the next csn assertion.
  - The first byte after reset is valid only if csn was high, or went high, before that frame.
- spi_active mirrors !csn_s, registered with the synchronizer; it is 0 at reset.

Decomposition:
- Package spi_pkg:
  - SPI_BITS=8.
  - Synchronizer idle values: SCK_IDLE=0, CSN_IDLE=1.
  - Function clog2 for pointer widths.
- Sub-module fifo_sync:
  - Single clock, DEPTH and WIDTH parameters.
  - Signals: push/pop/full/empty/head.
  - Asynchronous active-low reset on the pointers only.
- Synchronizers are inline generate chains; no separate module.

Test Plan:
- Single byte: csn low, shift 0xA5 MSB first at clk/8 sck, csn high -> rx_valid rises SYNC_STAGES+1 cycles after the 8th sck rise at the pad; rx_data=0xA5; pop with rx_ready -> rx_valid=0.
- Partial byte: csn low, 5 sck rises, csn high, then full byte 0x3C -> only 0x3C received; no stray byte.
- Overrun: rx_ready=0, send DEPTH+1 bytes 0x01..0x05 (DEPTH=4) -> FIFO holds 0x01..0x04, rx_overrun=1. Then pulse rx_overrun_clr -> 0. Then drain -> 0x01,0x02,0x03,0x04 in order.
- Full with simultaneous pop: FIFO full, hold rx_ready=1 so a pop coincides with a byte-complete push -> no overrun; order preserved.
- Clear versus set collision: assert rx_overrun_clr in the same cycle as a drop -> rx_overrun remains 1.
- Reset mid-frame: assert rst_n=0 after 4 bits, release, complete the frame, then send 0x5A in a new frame -> only 0x5A received; all outputs 0 during reset.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the sampled SPI receiver: frame width, synchronizer idle
// levels and a constant-foldable log2 for pointer sizing.
package spi_pkg;

    localparam int SPI_BITS = 8;

    localparam logic SCK_IDLE = 1'b0;
    localparam logic CSN_IDLE = 1'b1;
    localparam logic SDI_IDLE = 1'b0;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with extra-MSB pointers; head is read combinationally.
// Only the pointers are reset, the storage array powers up undefined.
module fifo_sync
    import spi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = mem_q[rd_q[AW-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle;
    // the freed slot is the one being written.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_rx_sampled.sv
// Mode-0 SPI slave receiver run entirely on clk: pads are oversampled through
// synchronizers, sck rises assemble MSB-first bytes into a small stream FIFO.
module spi_rx_sampled
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_sck,
    input  logic                spi_csn,
    input  logic                spi_sdi,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_overrun,
    input  logic                rx_overrun_clr,
    output logic                spi_active
);

    localparam int CW = clog2(SPI_BITS);

    // Each stage carries {sdi, csn, sck} so all three pads see equal latency.
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        logic [2:0] q;
        if (i == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= {SDI_IDLE, CSN_IDLE, SCK_IDLE};
                else        q <= {spi_sdi, spi_csn, spi_sck};
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= {SDI_IDLE, CSN_IDLE, SCK_IDLE};
                else        q <= g_sync[i-1].q;
            end
        end
    end

    logic sck_s, csn_s, sdi_s;
    assign {sdi_s, csn_s, sck_s} = g_sync[SYNC_STAGES-1].q;

    logic                sck_prev_q;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SPI_BITS-1:0] shift_q, shift_d;
    logic                ovr_q, ovr_d;
    logic                sck_rise;
    logic [SPI_BITS-1:0] byte_w;
    logic                push;
    logic                pop;
    logic                full, empty;
    logic [SPI_BITS-1:0] head;

    assign sck_rise = sck_s && !sck_prev_q && !csn_s;
    assign byte_w   = {shift_q[SPI_BITS-2:0], sdi_s};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        if (csn_s) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (sck_rise) begin
            if (bit_cnt_q == CW'(SPI_BITS - 1)) begin
                push      = 1'b1;
                bit_cnt_d = '0;
                shift_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = byte_w;
            end
        end
    end

    assign pop = rx_ready && !empty;

    // A fresh drop outranks a clear arriving in the same cycle.
    always_comb begin
        ovr_d = ovr_q;
        if (push && full && !pop) ovr_d = 1'b1;
        else if (rx_overrun_clr)  ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ovr_q      <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ovr_q      <= ovr_d;
        end
    end

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (SPI_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (byte_w),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Storage is not reset, so the head is masked to keep rx_data at 0 when empty.
    assign rx_data    = empty ? '0 : head;
    assign rx_valid   = !empty;
    assign rx_overrun = ovr_q;
    assign spi_active = !csn_s;

endmodule

// File: tb/tb_spi_rx_sampled.sv
// Bench for spi_rx_sampled: directed SPI frames, a byte-queue model fed by the
// driver with the expected arrival cycle, and a per-cycle compare process.
module tb_spi_rx_sampled;

    localparam int S = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sdi = 1'b0;
    logic       rx_ready = 1'b0;
    logic       rx_overrun_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       spi_active;

    always #5 clk = ~clk;

    spi_rx_sampled #(.SYNC_STAGES(S), .DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_sck        (spi_sck),
        .spi_csn        (spi_csn),
        .spi_sdi        (spi_sdi),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_overrun     (rx_overrun),
        .rx_overrun_clr (rx_overrun_clr),
        .spi_active     (spi_active)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int vrise  = -1;
    int last8  = 0;
    logic v_prev = 1'b0;

    // Model state: delivered bytes, bytes in flight with their arrival cycle,
    // chip-select changes with the cycle they were driven.
    logic [7:0] mq[$];
    int         pend_c[$];
    logic [7:0] pend_b[$];
    int         ev_c[$];
    logic       ev_v[$];
    logic       m_ovr = 1'b0;
    logic       m_act = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        bit         pop_m, psh_m, full_m, drop_m;
        logic [7:0] pb;
        cyc++;
        if (!rst_n) begin
            mq.delete(); pend_c.delete(); pend_b.delete();
            ev_c.delete(); ev_v.delete();
            m_ovr = 1'b0;
            m_act = 1'b0;
        end else begin
            pop_m  = rx_ready && (mq.size() > 0);
            full_m = (mq.size() == D);
            psh_m  = 1'b0;
            drop_m = 1'b0;
            pb     = 8'h00;
            if (pend_c.size() > 0 && pend_c[0] == cyc) begin
                psh_m = 1'b1;
                pb = pend_b.pop_front();
                void'(pend_c.pop_front());
            end
            if (pop_m) void'(mq.pop_front());
            if (psh_m) begin
                if (!full_m || pop_m) mq.push_back(pb);
                else drop_m = 1'b1;
            end
            if (drop_m) m_ovr = 1'b1;
            else if (rx_overrun_clr) m_ovr = 1'b0;
            while (ev_c.size() > 0 && ev_c[0] + S == cyc) begin
                m_act = !ev_v[0];
                void'(ev_c.pop_front());
                void'(ev_v.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("rx_valid", rx_valid, mq.size() != 0);
        if (rx_valid && mq.size() > 0) chk("rx_data", rx_data, mq[0]);
        chk("rx_overrun", rx_overrun, m_ovr);
        chk("spi_active", spi_active, m_act);
        if (!rst_n) chk("rst_rx_data", rx_data, 0);
        if (rx_valid && !v_prev) vrise = cyc;
        v_prev = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_csn(input logic v);
        spi_csn = v;
        ev_c.push_back(cyc);
        ev_v.push_back(v);
    endtask

    // sck at clk/8: 4 cycles low with sdi set up, 4 cycles high.
    task automatic send_bits(input logic [7:0] b, input int n, input bit sched,
                             input bit pop_at, input bit clr_at);
        for (int i = 0; i < n; i++) begin
            spi_sdi = b[7-i];
            tick(4);
            spi_sck = 1'b1;
            if (i == 7) begin
                last8 = cyc;
                if (sched) begin
                    pend_c.push_back(cyc + S + 1);
                    pend_b.push_back(b);
                end
            end
            if (i == n - 1 && (pop_at || clr_at)) begin
                tick(S);
                rx_ready = pop_at;
                rx_overrun_clr = clr_at;
                tick(1);
                rx_ready = 1'b0;
                rx_overrun_clr = 1'b0;
                tick(4 - S - 1);
            end else begin
                tick(4);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic begin_frame;
        set_csn(1'b0);
        tick(4);
    endtask

    task automatic end_frame;
        tick(4);
        set_csn(1'b1);
        tick(4);
    endtask

    task automatic drain_expect(input logic [7:0] e);
        chk("drain_valid", rx_valid, 1);
        chk("drain_data", rx_data, e);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        tick(3);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 0);
        chk("reset_overrun", rx_overrun, 0);
        chk("reset_active", spi_active, 0);
        rst_n = 1'b1;
        ev_c.push_back(cyc);
        ev_v.push_back(spi_csn);
        tick(4);

        // single byte, latency from pad to rx_valid
        begin_frame;
        send_byte(8'hA5);
        end_frame;
        chk("single_latency", vrise - last8, 3);
        chk("single_data", rx_data, 8'hA5);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("single_popped", rx_valid, 0);

        // partial byte discarded by deselect
        begin_frame;
        send_bits(8'hFF, 5, 1'b0, 1'b0, 1'b0);
        end_frame;
        chk("partial_none", rx_valid, 0);
        begin_frame;
        send_byte(8'h3C);
        end_frame;
        drain_expect(8'h3C);
        chk("partial_no_stray", rx_valid, 0);

        // overrun on the fifth byte
        begin_frame;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        end_frame;
        chk("overrun_set", rx_overrun, 1);
        rx_overrun_clr = 1'b1;
        tick(1);
        rx_overrun_clr = 1'b0;
        chk("overrun_clr", rx_overrun, 0);
        for (int i = 1; i <= 4; i++) drain_expect(8'(i));
        chk("overrun_drained", rx_valid, 0);

        // full FIFO, pop coincides with push
        begin_frame;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_bits(8'h55, 8, 1'b1, 1'b1, 1'b0);
        end_frame;
        chk("fullpop_no_overrun", rx_overrun, 0);

        // clear colliding with a drop
        begin_frame;
        send_bits(8'h66, 8, 1'b1, 1'b0, 1'b1);
        end_frame;
        chk("collision_set_wins", rx_overrun, 1);
        drain_expect(8'h22); drain_expect(8'h33);
        drain_expect(8'h44); drain_expect(8'h55);
        chk("collision_drained", rx_valid, 0);
        rx_overrun_clr = 1'b1;
        tick(1);
        rx_overrun_clr = 1'b0;
        chk("collision_clr", rx_overrun, 0);

        // reset mid-frame with a byte still queued
        begin_frame;
        send_byte(8'h77);
        end_frame;
        chk("pre_reset_data", rx_data, 8'h77);
        begin_frame;
        send_bits(8'hF0, 4, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(3);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 0);
        chk("midrst_active", spi_active, 0);
        rst_n = 1'b1;
        ev_c.push_back(cyc);
        ev_v.push_back(spi_csn);
        tick(4);
        send_bits(8'h0F, 4, 1'b0, 1'b0, 1'b0);
        end_frame;
        chk("midrst_no_stray", rx_valid, 0);
        begin_frame;
        send_byte(8'h5A);
        end_frame;
        drain_expect(8'h5A);
        chk("midrst_drained", rx_valid, 0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
